// File: rtl/tempo_entrada_if.sv
// tempo_entrada_if: keypad/button inputs and counter-chain outputs of the
// microwave time-entry stage, grouped as one bundle.
//   master : drives key_valid/key_code/start/stop/door_closed/zero,
//            observes data_*, loadn, en, done, err, state
//   slave  : the tempo_entrada controller side
interface tempo_entrada_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       start;
  logic       stop;
  logic       door_closed;
  logic       zero;
  logic [3:0] data_mt;
  logic [3:0] data_mu;
  logic [3:0] data_st;
  logic [3:0] data_su;
  logic       loadn;
  logic       en;
  logic       done;
  logic       err;
  logic [2:0] state;

  modport master (
    output key_valid, key_code, start, stop, door_closed, zero,
    input  data_mt, data_mu, data_st, data_su, loadn, en, done, err, state
  );

  modport slave (
    input  key_valid, key_code, start, stop, door_closed, zero,
    output data_mt, data_mu, data_st, data_su, loadn, en, done, err, state
  );
endinterface

// File: rtl/tempo_entrada.sv
// tempo_entrada: keypad time entry and cooking control for the microwave
// timer. Digits are shifted in right-to-left into an MM:SS BCD buffer; on a
// valid start the buffer is parallel-loaded into the counter chain (loadn
// low for one cycle) and the chain's count enable is gated until it reports
// zero, with pause on door-open or stop.
//   clk   : system clock, rising edge
//   clear : synchronous active-high reset
//   bus   : tempo_entrada_if.slave (key/start/stop/door/zero in;
//           data_*, loadn, en, done, err, state out; all outputs registered)
//
// state | meaning
// IDLE  | buffer empty, waiting for first digit
// ENTRY | collecting up to four digits
// LOAD  | loadn low for one cycle, digits presented to the chain
// RUN   | en high, chain counting down
// PAUSE | en low, waiting for start (resume) or stop (cancel)
// DONE  | one-cycle done pulse, then back to IDLE
module tempo_entrada (
  input  logic           clk,
  input  logic           clear,
  tempo_entrada_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_PAUSE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] mt_q, mu_q, st_q, su_q;
  logic [3:0] mt_d, mu_d, st_d, su_d;
  logic [2:0] ndig_q, ndig_d;
  logic       loadn_q, en_q, done_q, err_q, err_d;

  logic       key_q, key_qq, start_q, start_qq, stop_q, stop_qq;
  logic [3:0] code_q;
  logic       ev_key, ev_start, ev_stop, start_ok;

  // Edge-detect registers preset to 1 so a level already high across
  // reset is not mistaken for a fresh press. The key code travels with the
  // strobe so the digit used is the one present when the press registered.
  always_ff @(posedge clk) begin
    if (clear) begin
      key_q    <= 1'b1;
      key_qq   <= 1'b1;
      start_q  <= 1'b1;
      start_qq <= 1'b1;
      stop_q   <= 1'b1;
      stop_qq  <= 1'b1;
      code_q   <= 4'd0;
    end else begin
      key_q    <= bus.key_valid;
      key_qq   <= key_q;
      start_q  <= bus.start;
      start_qq <= start_q;
      stop_q   <= bus.stop;
      stop_qq  <= stop_q;
      code_q   <= bus.key_code;
    end
  end

  // Priority stop > start > key; losers in the same cycle are dropped.
  assign ev_stop  = stop_q & ~stop_qq;
  assign ev_start = start_q & ~start_qq & ~ev_stop;
  assign ev_key   = key_q & ~key_qq & ~ev_stop & ~ev_start & (code_q <= 4'd9);

  // Second-tens above 5 is not a valid time; an all-zero time is rejected.
  assign start_ok = bus.door_closed & (st_q <= 4'd5) &
                    ({mt_q, mu_q, st_q, su_q} != 16'h0000);

  always_comb begin
    state_d = state_q;
    mt_d    = mt_q;
    mu_d    = mu_q;
    st_d    = st_q;
    su_d    = su_q;
    ndig_d  = ndig_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ev_key) begin
          su_d    = code_q;
          ndig_d  = 3'd1;
          state_d = S_ENTRY;
        end else if (ev_start) begin
          err_d = 1'b1;
        end
      end
      S_ENTRY: begin
        if (ev_stop) begin
          state_d = S_IDLE;
        end else if (ev_start) begin
          if (start_ok) state_d = S_LOAD;
          else          err_d   = 1'b1;
        end else if (ev_key && ndig_q < 3'd4) begin
          mt_d   = mu_q;
          mu_d   = st_q;
          st_d   = su_q;
          su_d   = code_q;
          ndig_d = ndig_q + 3'd1;
        end
      end
      S_LOAD:  state_d = S_RUN;
      S_RUN: begin
        if (bus.zero)             state_d = S_DONE;
        else if (!bus.door_closed) state_d = S_PAUSE;
        else if (ev_stop)          state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (ev_stop) begin
          state_d = S_IDLE;
        end else if (ev_start) begin
          if (bus.door_closed) state_d = S_RUN;
          else                 err_d   = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Every way back to IDLE empties the buffer.
    if (state_d == S_IDLE) begin
      mt_d   = 4'd0;
      mu_d   = 4'd0;
      st_d   = 4'd0;
      su_d   = 4'd0;
      ndig_d = 3'd0;
    end
  end

  // Outputs are decoded from the next state so they are registers that line
  // up with the state they describe.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= S_IDLE;
      mt_q    <= 4'd0;
      mu_q    <= 4'd0;
      st_q    <= 4'd0;
      su_q    <= 4'd0;
      ndig_q  <= 3'd0;
      loadn_q <= 1'b1;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mt_q    <= mt_d;
      mu_q    <= mu_d;
      st_q    <= st_d;
      su_q    <= su_d;
      ndig_q  <= ndig_d;
      loadn_q <= (state_d != S_LOAD);
      en_q    <= (state_d == S_RUN);
      done_q  <= (state_d == S_DONE);
      err_q   <= err_d;
    end
  end

  assign bus.data_mt = mt_q;
  assign bus.data_mu = mu_q;
  assign bus.data_st = st_q;
  assign bus.data_su = su_q;
  assign bus.loadn   = loadn_q;
  assign bus.en      = en_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_tempo_entrada.sv
// Testbench for tempo_entrada: a directed vector table, hand-written corner
// sequences, then randomized stimulus against a queue-based reference model.
module tb_tempo_entrada;

  logic clk;
  logic clear;
  tempo_entrada_if bus ();

  tempo_entrada dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_ENTRY = 1, M_LOAD = 2, M_RUN = 3, M_PAUSE = 4, M_DONE = 5;
  int   m_mode;
  int   dq[$];              // digits entered, oldest first
  bit   m_loadn, m_en, m_done, m_err;
  bit   kv_h1, kv_h2, sa_h1, sa_h2, sp_h1, sp_h2;   // samples at last two edges
  logic [3:0] code_h1;

  function automatic logic [15:0] pack_digits();
    logic [15:0] v = 16'h0000;
    foreach (dq[i]) v = {v[11:0], 4'(dq[i])};
    return v;
  endfunction

  task automatic model_edge(input bit clr, input bit kv, input logic [3:0] code,
                            input bit sta, input bit stp, input bit door, input bit zr);
    bit e_stop, e_start, e_key;
    logic [15:0] v;
    if (clr) begin
      m_mode = M_IDLE; dq.delete();
      m_loadn = 1; m_en = 0; m_done = 0; m_err = 0;
      kv_h1 = 1; kv_h2 = 1; sa_h1 = 1; sa_h2 = 1; sp_h1 = 1; sp_h2 = 1;
      code_h1 = 4'd0;
      return;
    end
    e_stop  = sp_h1 && !sp_h2;
    e_start = sa_h1 && !sa_h2 && !e_stop;
    e_key   = kv_h1 && !kv_h2 && !e_stop && !e_start && (code_h1 < 10);
    v = pack_digits();
    m_err = 0; m_done = 0;
    case (m_mode)
      M_IDLE: begin
        if (e_key) begin dq.push_back(int'(code_h1)); m_mode = M_ENTRY; end
        else if (e_start) m_err = 1;
      end
      M_ENTRY: begin
        if (e_stop) begin m_mode = M_IDLE; dq.delete(); end
        else if (e_start) begin
          if (door && v[7:4] <= 5 && v != 0) m_mode = M_LOAD;
          else m_err = 1;
        end else if (e_key && dq.size() < 4) dq.push_back(int'(code_h1));
      end
      M_LOAD: m_mode = M_RUN;
      M_RUN: begin
        if (zr) m_mode = M_DONE;
        else if (!door || e_stop) m_mode = M_PAUSE;
      end
      M_PAUSE: begin
        if (e_stop) begin m_mode = M_IDLE; dq.delete(); end
        else if (e_start) begin
          if (door) m_mode = M_RUN;
          else m_err = 1;
        end
      end
      default: begin m_mode = M_IDLE; dq.delete(); end
    endcase
    m_done  = (m_mode == M_DONE);
    m_loadn = (m_mode != M_LOAD);
    m_en    = (m_mode == M_RUN);
    kv_h2 = kv_h1; kv_h1 = kv;
    sa_h2 = sa_h1; sa_h1 = sta;
    sp_h2 = sp_h1; sp_h1 = stp;
    code_h1 = code;
  endtask

  function automatic logic [31:0] model_vec();
    return {9'd0, 3'(m_mode), pack_digits(), m_loadn, m_en, m_done, m_err};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {9'd0, bus.state, bus.data_mt, bus.data_mu, bus.data_st, bus.data_su,
            bus.loadn, bus.en, bus.done, bus.err};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive inputs away from the edge, clock, compare with model.
  task automatic step(input bit clr, input bit kv, input logic [3:0] code,
                      input bit sta, input bit stp, input bit door, input bit zr);
    clear = clr; bus.key_valid = kv; bus.key_code = code;
    bus.start = sta; bus.stop = stp; bus.door_closed = door; bus.zero = zr;
    @(posedge clk);
    model_edge(clr, kv, code, sta, stp, door, zr);
    #1;
    chk("model", dut_vec(), model_vec());
  endtask

  task automatic press(input logic [3:0] code, input bit door);
    step(0, 1, code, 0, 0, door, 0);
    step(0, 0, code, 0, 0, door, 0);
  endtask

  task automatic pulse_start(input bit door);
    step(0, 0, 0, 1, 0, door, 0);
    step(0, 0, 0, 0, 0, door, 0);
  endtask

  task automatic pulse_stop(input bit door);
    step(0, 0, 0, 0, 1, door, 0);
    step(0, 0, 0, 0, 0, door, 0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit clr; bit kv; logic [3:0] code; bit sta; bit stp; bit zr;
    logic [2:0] st; logic [15:0] data; bit ldn; bit en; bit dn; bit er;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit clr, bit kv, logic [3:0] code, bit sta, bit stp, bit zr,
                              logic [2:0] st, logic [15:0] data, bit ldn, bit en, bit dn, bit er);
    vec_t v;
    v.clr = clr; v.kv = kv; v.code = code; v.sta = sta; v.stp = stp; v.zr = zr;
    v.st = st; v.data = data; v.ldn = ldn; v.en = en; v.dn = dn; v.er = er;
    tbl.push_back(v);
  endfunction

  initial begin
    clear = 1; bus.key_valid = 0; bus.key_code = 0; bus.start = 0;
    bus.stop = 0; bus.door_closed = 1; bus.zero = 0;

    //  clr kv code sta stp zr | st data     ldn en dn er
    add(1, 0, 0,  0, 0, 0,  0, 16'h0000, 1, 0, 0, 0);
    add(0, 0, 0,  0, 0, 0,  0, 16'h0000, 1, 0, 0, 0);
    add(0, 1, 1,  0, 0, 0,  0, 16'h0000, 1, 0, 0, 0);
    add(0, 0, 1,  0, 0, 0,  1, 16'h0001, 1, 0, 0, 0);
    add(0, 1, 3,  0, 0, 0,  1, 16'h0001, 1, 0, 0, 0);
    add(0, 0, 3,  0, 0, 0,  1, 16'h0013, 1, 0, 0, 0);
    add(0, 1, 0,  0, 0, 0,  1, 16'h0013, 1, 0, 0, 0);
    add(0, 0, 0,  0, 0, 0,  1, 16'h0130, 1, 0, 0, 0);
    add(0, 1, 12, 0, 0, 0,  1, 16'h0130, 1, 0, 0, 0);
    add(0, 0, 12, 0, 0, 0,  1, 16'h0130, 1, 0, 0, 0);
    add(0, 1, 7,  0, 0, 0,  1, 16'h0130, 1, 0, 0, 0);
    add(0, 0, 7,  0, 0, 0,  1, 16'h1307, 1, 0, 0, 0);
    add(0, 1, 9,  0, 0, 0,  1, 16'h1307, 1, 0, 0, 0);
    add(0, 0, 9,  0, 0, 0,  1, 16'h1307, 1, 0, 0, 0);
    add(0, 1, 4,  0, 0, 0,  1, 16'h1307, 1, 0, 0, 0);
    add(0, 0, 4,  0, 0, 0,  1, 16'h1307, 1, 0, 0, 0);
    add(0, 0, 0,  0, 1, 0,  1, 16'h1307, 1, 0, 0, 0);
    add(0, 0, 0,  0, 0, 0,  0, 16'h0000, 1, 0, 0, 0);
    add(0, 1, 0,  0, 0, 0,  0, 16'h0000, 1, 0, 0, 0);
    add(0, 0, 0,  0, 0, 0,  1, 16'h0000, 1, 0, 0, 0);
    add(0, 1, 1,  0, 0, 0,  1, 16'h0000, 1, 0, 0, 0);
    add(0, 0, 1,  0, 0, 0,  1, 16'h0001, 1, 0, 0, 0);
    add(0, 1, 0,  0, 0, 0,  1, 16'h0001, 1, 0, 0, 0);
    add(0, 0, 0,  0, 0, 0,  1, 16'h0010, 1, 0, 0, 0);
    add(0, 1, 5,  0, 0, 0,  1, 16'h0010, 1, 0, 0, 0);
    add(0, 0, 5,  0, 0, 0,  1, 16'h0105, 1, 0, 0, 0);
    add(0, 0, 0,  1, 0, 0,  1, 16'h0105, 1, 0, 0, 0);
    add(0, 0, 0,  0, 0, 0,  2, 16'h0105, 0, 0, 0, 0);
    add(0, 0, 0,  0, 0, 0,  3, 16'h0105, 1, 1, 0, 0);
    add(0, 0, 0,  0, 0, 0,  3, 16'h0105, 1, 1, 0, 0);
    add(0, 0, 0,  0, 0, 1,  5, 16'h0105, 1, 0, 1, 0);
    add(0, 0, 0,  0, 0, 0,  0, 16'h0000, 1, 0, 0, 0);
    add(0, 1, 0,  0, 0, 0,  0, 16'h0000, 1, 0, 0, 0);
    add(0, 0, 0,  0, 0, 0,  1, 16'h0000, 1, 0, 0, 0);
    add(0, 1, 0,  0, 0, 0,  1, 16'h0000, 1, 0, 0, 0);
    add(0, 0, 0,  0, 0, 0,  1, 16'h0000, 1, 0, 0, 0);
    add(0, 1, 7,  0, 0, 0,  1, 16'h0000, 1, 0, 0, 0);
    add(0, 0, 7,  0, 0, 0,  1, 16'h0007, 1, 0, 0, 0);
    add(0, 1, 0,  0, 0, 0,  1, 16'h0007, 1, 0, 0, 0);
    add(0, 0, 0,  0, 0, 0,  1, 16'h0070, 1, 0, 0, 0);
    add(0, 0, 0,  1, 0, 0,  1, 16'h0070, 1, 0, 0, 0);
    add(0, 0, 0,  0, 0, 0,  1, 16'h0070, 1, 0, 0, 1);
    add(0, 0, 0,  0, 0, 0,  1, 16'h0070, 1, 0, 0, 0);
    add(0, 0, 0,  0, 1, 0,  1, 16'h0070, 1, 0, 0, 0);
    add(0, 0, 0,  0, 0, 0,  0, 16'h0000, 1, 0, 0, 0);
    add(0, 0, 0,  1, 0, 0,  0, 16'h0000, 1, 0, 0, 0);
    add(0, 0, 0,  0, 0, 0,  0, 16'h0000, 1, 0, 0, 1);
    add(0, 0, 0,  0, 0, 0,  0, 16'h0000, 1, 0, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].clr, tbl[i].kv, tbl[i].code, tbl[i].sta, tbl[i].stp, 1'b1, tbl[i].zr);
      chk($sformatf("vec%0d", i), dut_vec(),
          {9'd0, tbl[i].st, tbl[i].data, tbl[i].ldn, tbl[i].en, tbl[i].dn, tbl[i].er});
    end

    // Door-open pause, rejected resume, resume without reload, stop twice.
    step(1, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    press(1, 1);
    press(0, 1);
    pulse_start(1);
    chk("load_pulse", 32'(bus.loadn), 32'd0);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("run_en", 32'(bus.en), 32'd1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("door_pause", {28'd0, bus.state, bus.en}, {28'd0, 3'd4, 1'b0});
    pulse_start(0);
    chk("pause_err", {28'd0, bus.state, bus.err}, {28'd0, 3'd4, 1'b1});
    step(0, 0, 0, 0, 0, 1, 0);
    pulse_start(1);
    chk("resume", {27'd0, bus.state, bus.loadn, bus.en}, {27'd0, 3'd3, 1'b1, 1'b1});
    pulse_stop(1);
    chk("stop_pause", {28'd0, bus.state, bus.en}, {28'd0, 3'd4, 1'b0});
    pulse_stop(1);
    chk("stop_idle", {13'd0, bus.state, bus.data_mt, bus.data_mu, bus.data_st, bus.data_su},
        {13'd0, 3'd0, 16'h0000});

    // Same-cycle stop and start in ENTRY: stop wins.
    press(4, 1);
    step(0, 0, 0, 1, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("stop_beats_start", {29'd0, bus.state}, 32'd0);

    // Key held high through clear is not a press.
    step(1, 1, 5, 0, 0, 1, 0);
    step(0, 1, 5, 0, 0, 1, 0);
    step(0, 1, 5, 0, 0, 1, 0);
    step(0, 0, 5, 0, 0, 1, 0);
    chk("held_key", {13'd0, bus.state, bus.data_mt, bus.data_mu, bus.data_st, bus.data_su},
        {13'd0, 3'd0, 16'h0000});

    // Start with door open in ENTRY is rejected, digits kept.
    press(2, 1);
    press(0, 1);
    pulse_start(0);
    chk("door_open_err", {12'd0, bus.state, bus.err, bus.data_mt, bus.data_mu, bus.data_st, bus.data_su},
        {12'd0, 3'd1, 1'b1, 16'h0020});

    // Clear in the middle of RUN.
    pulse_start(1);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("pre_clear_run", {28'd0, bus.state, bus.en}, {28'd0, 3'd3, 1'b1});
    step(1, 0, 0, 0, 0, 1, 0);
    chk("clear_run", dut_vec(), {9'd0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});

    // Randomized run against the model.
    begin
      bit kv = 0;
      logic [3:0] code = 0;
      step(0, 0, 0, 0, 0, 1, 0);
      for (int n = 0; n < 4000; n++) begin
        bit sta, stp, door, zr, clr;
        if ($urandom_range(0, 2) == 0) kv = ~kv;
        if (!kv) code = 4'($urandom_range(0, 15));
        sta  = ($urandom_range(0, 7) == 0);
        stp  = ($urandom_range(0, 19) == 0);
        door = ($urandom_range(0, 9) != 0);
        zr   = ($urandom_range(0, 14) == 0);
        clr  = ($urandom_range(0, 299) == 0);
        step(clr, kv, code, sta, stp, door, zr);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
